// File: rtl/sdp_ram_reader.sv
// Streams the contents of a simple-dual-port RAM read port out as an AXI4-Stream master.
// Optional macro SDP_READER_WINDOW_EN adds start_addr/word_count to read a wrapped sub-window.
module sdp_ram_reader #(
  parameter int DW     = 512,
  parameter int DD     = 16384,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
`ifdef SDP_READER_WINDOW_EN
  input  logic [$clog2(DD)-1:0] start_addr,
  input  logic [$clog2(DD):0]   word_count,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(DD)-1:0] addrb,
  input  logic [DW-1:0]         dob,
  output logic [DW-1:0]         AXIS_TDATA,
  output logic                  AXIS_TVALID,
  output logic                  AXIS_TLAST,
  input  logic                  AXIS_TREADY,
  output logic [1:0]            fsm_state
);

  // Handshake: a beat transfers on a rising edge where AXIS_TVALID && AXIS_TREADY;
  // once TVALID is raised it and TDATA hold until that transfer happens.

  localparam int AW = $clog2(DD);
  localparam logic [AW:0] DD_W = (AW+1)'(DD);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW:0]       rd_cnt;
  logic [AW:0]       beat_cnt;
  logic [AW:0]       n_words;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       req_words;
  logic [AW-1:0]     req_addr;
  logic [RD_LAT-1:0] vld_sr;
  logic [DW-1:0]     fifo_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_cnt;
  logic [2:0]        in_flight;
  logic [3:0]        used;
  logic              start_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_beat;

`ifdef SDP_READER_WINDOW_EN
  assign req_words = (word_count > DD_W) ? DD_W : word_count;
  assign req_addr  = start_addr;
`else
  assign req_words = DD_W;
  assign req_addr  = '0;
`endif

  assign start_ok    = start && (state == IDLE);
  assign push        = vld_sr[RD_LAT-1];
  assign AXIS_TVALID = (fifo_cnt != 3'd0);
  assign AXIS_TDATA  = fifo_mem[rd_ptr];
  assign pop         = AXIS_TVALID && AXIS_TREADY;
  assign last_beat   = (beat_cnt == n_words - ONE);
  assign AXIS_TLAST  = AXIS_TVALID && last_beat;
  assign addrb       = base_addr + rd_cnt[AW-1:0];
  assign fsm_state   = state;

  always_comb begin
    in_flight = 3'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + {2'b00, vld_sr[i]};
    end
  end

  // A slot freed by this cycle's pop is reusable at once; otherwise RD_LAT=3 would bubble.
  assign used  = {1'b0, fifo_cnt} + {1'b0, in_flight} - {3'b000, pop};
  assign issue = (state == READ) && (used < 4'd4);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok && (req_words != '0)) state_nxt = READ;
      READ:    if (issue && (rd_cnt == n_words - ONE)) state_nxt = DRAIN;
      DRAIN:   if (pop && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt    <= '0;
      beat_cnt  <= '0;
      n_words   <= DD_W;
      base_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (start_ok) begin
        rd_cnt    <= '0;
        beat_cnt  <= '0;
        n_words   <= req_words;
        base_addr <= req_addr;
      end else begin
        if (issue) rd_cnt <= rd_cnt + ONE;
        if (pop)   beat_cnt <= beat_cnt + ONE;
      end
      // An empty window completes on the start edge itself.
      done <= ((state == DRAIN) && pop && last_beat) || (start_ok && (req_words == '0));
      if (start_ok)  busy <= 1'b1;
      else if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_sr   <= '0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dob;
  end

endmodule
